tap_ctrl: RTL and testbench
===========================

Name: tap_ctrl

Overview:
- Single-clock IEEE 1149.1-style TAP controller for the on-chip boundary-scan chain (bsr cells) and the BIST/BILBO control lines.
- Decodes the TMS/TDI stream and issues one-cycle capture/update enables plus a shift level to the boundary chain.
- Holds the instruction register and bypass register, and muxes the selected register onto TDO.
- Sits between the chip test pins and the boundary/BILBO scan chains.

Parameters:
IR_W, 4, instruction register width (min 2)
IDCODE_VAL, 32'h1000_0001, device ID returned by IDCODE (bit0 must be 1; used only with TAP_IDCODE_EN)

Ports:
clock  in  1  system/test clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
tms  in  1  test mode select, sampled every rising edge
tdi  in  1  test data in
tdo  out  1  test data out
tdo_en  out  1  high only in Shift-IR / Shift-DR
bsr_scan_in  out  1  serial data into boundary chain (= tdi)
bsr_scan_out  in  1  serial data returning from boundary chain
bsr_shift  out  1  boundary chain shift select (level)
bsr_capture  out  1  one-cycle capture enable to boundary chain
bsr_update  out  1  one-cycle update enable to boundary chain
bsr_sel  out  1  boundary cells drive outputs (EXTEST active)
bist_run  out  1  BIST run request to BILBO controller
bist_done  in  1  BIST complete flag, captured into the DR
tap_state  out  4  current TAP state encoding, for debug

Behaviour:
- Reset: rst=1 at an edge -> state TEST_LOGIC_RESET; IR=BYPASS (IDCODE with macro); bypass reg=0.
  All outputs 0 except tap_state=TLR encoding.
- FSM: 16 standard states, transitions on tms at each rising edge.
  - TLR: tms=0 -> RTI, 1 -> TLR.
  - RTI: 1 -> SELDR, 0 -> RTI.
  - SELDR: 0 -> CAPDR, 1 -> SELIR. SELIR: 0 -> CAPIR, 1 -> TLR.
  - CAPx: 0 -> SHx, 1 -> EX1x. SHx: 1 -> EX1x, 0 -> SHx.
  - EX1x: 0 -> PAUSEx, 1 -> UPDx. PAUSEx: 1 -> EX2x, 0 -> PAUSEx.
  - EX2x: 0 -> SHx, 1 -> UPDx. UPDx: 1 -> SELDR, 0 -> RTI.
- Five consecutive tms=1 edges reach TLR from any state. In TLR, IR is forced to its reset value every cycle.
- Instructions (IR_W=4):
  - EXTEST=0000: DR=boundary chain, bsr_sel=1.
  - SAMPLE=0001: DR=boundary chain, bsr_sel=0.
  - IDCODE=0010: DR=32-bit ID; BYPASS without macro.
  - RUNBIST=0011: DR=1-bit bist_done.
  - BYPASS=1111 and all undefined codes: DR=1-bit bypass.
- IR shift register:
  - CAPIR loads {IR_W-2 zeros, 01}.
  - SHIR shifts right; tdi enters the MSB; the LSB is presented on tdo.
  - UPDIR copies the shift register to the active IR. The active IR changes only in UPDIR or TLR.
- tdo: combinational LSB of the selected shift register while in SHIR/SHDR, else 0.
  - The bit shifted out at edge n is the value visible on tdo before edge n.
  - In SHDR with a boundary instruction, tdo=bsr_scan_out.
- Boundary outputs:
  - bsr_capture=1 exactly in CAPDR when the DR is the boundary chain.
  - bsr_shift=1 in SHDR only.
  - bsr_update=1 exactly in UPDDR.
  - All are decoded from the registered state (Moore), so each asserts the cycle the FSM is in that state.
- bsr_sel: registered from the active IR; changes the cycle after UPDIR; held through PAUSE/EXIT states.
- Bypass reg: cleared in CAPDR, loaded from tdi in SHDR.
- RUNBIST: bist_run=1 while the state is RTI and IR=RUNBIST; deasserts the cycle the state leaves RTI.
- rst mid-shift: partial shift contents are discarded. IR and bsr_sel revert at the next edge, and no update pulse is generated.

Optional Feature:
- Macro: TAP_IDCODE_EN.
- Defined: 32-bit ID register, loaded with IDCODE_VAL in CAPDR and shifted LSB first in SHDR. Reset IR = IDCODE.
- Undefined: no ID register; IR 0010 decodes as BYPASS and reset IR = BYPASS.

Test Plan:
- From RTI, tms=1,1,1,1,1 -> state TLR, tdo_en=0, bsr_sel=0 (IR=BYPASS, or IDCODE with macro).
- IR scan, shifting tdi=0000 -> tdo during SHIR reads 1,0,0,0. The cycle after UPDIR, bsr_sel=1.
- BYPASS: shift DR with tdi=1,0,1,1 -> tdo=0,1,0,1 (one-bit delay, leading 0 from capture).
- EXTEST DR scan of 8 cells:
  - bsr_capture high exactly 1 cycle.
  - bsr_shift high for 8 cycles (with 7 SHDR cycles + exit edge the shift count matches the stepped tms).
  - bsr_update high exactly 1 cycle; tdo tracks bsr_scan_out.
- With TAP_IDCODE_EN, reset then go straight to SHDR and shift 32 bits -> tdo stream LSB first = 32'h1000_0001.
  Without the macro -> a single 0, then tdi delayed by one cycle.
- Load RUNBIST, enter RTI -> bist_run=1. Assert rst mid-SHDR -> next cycle state TLR, bist_run=0, bsr_update never pulses.

Source files
------------

// File: rtl/tap_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tap_ctrl_if                                                       |
// | Desc    : Test-pin and boundary/BILBO signal bundle for the TAP controller. |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface tap_ctrl_if;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic       bsr_scan_in;
  logic       bsr_scan_out;
  logic       bsr_shift;
  logic       bsr_capture;
  logic       bsr_update;
  logic       bsr_sel;
  logic       bist_run;
  logic       bist_done;
  logic [3:0] tap_state;

  modport master (
    output tms, tdi, bsr_scan_out, bist_done,
    input  tdo, tdo_en, bsr_scan_in, bsr_shift, bsr_capture, bsr_update,
           bsr_sel, bist_run, tap_state
  );

  modport slave (
    input  tms, tdi, bsr_scan_out, bist_done,
    output tdo, tdo_en, bsr_scan_in, bsr_shift, bsr_capture, bsr_update,
           bsr_sel, bist_run, tap_state
  );
endinterface
`default_nettype wire

// File: rtl/tap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tap_ctrl                                                          |
// | Desc    : Single-clock 1149.1-style TAP controller driving the boundary     |
// |           chain and BIST request; optional ID register via TAP_IDCODE_EN.   |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tap_ctrl #(
  parameter int unsigned IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input wire logic  clock,
  input wire logic  rst,
  tap_ctrl_if.slave tap
);

  typedef enum logic [3:0] {
    ST_EX2DR   = 4'h0,
    ST_EX1DR   = 4'h1,
    ST_SHDR    = 4'h2,
    ST_PAUSEDR = 4'h3,
    ST_SELIR   = 4'h4,
    ST_UPDDR   = 4'h5,
    ST_CAPDR   = 4'h6,
    ST_SELDR   = 4'h7,
    ST_EX2IR   = 4'h8,
    ST_EX1IR   = 4'h9,
    ST_SHIR    = 4'hA,
    ST_PAUSEIR = 4'hB,
    ST_RTI     = 4'hC,
    ST_UPDIR   = 4'hD,
    ST_CAPIR   = 4'hE,
    ST_TLR     = 4'hF
  } state_e;

  typedef enum logic [1:0] {
    DR_BSR  = 2'd0,
    DR_ID   = 2'd1,
    DR_BIST = 2'd2,
    DR_BYP  = 2'd3
  } dr_e;

  localparam logic [IR_W-1:0] c_IR_EXTEST  = IR_W'(0);
  localparam logic [IR_W-1:0] c_IR_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] c_IR_RUNBIST = IR_W'(3);
  localparam logic [IR_W-1:0] c_IR_BYPASS  = {IR_W{1'b1}};
  localparam logic [IR_W-1:0] c_IR_CAPTURE = IR_W'(1);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] c_IR_IDCODE  = IR_W'(2);
  localparam logic [IR_W-1:0] c_IR_RESET   = c_IR_IDCODE;
`else
  localparam logic [IR_W-1:0] c_IR_RESET   = c_IR_BYPASS;
`endif

  if (IDCODE_VAL[0] != 1'b1 || IR_W < 2) begin : g_param_check
    $error("tap_ctrl: IDCODE_VAL[0] must be 1 and IR_W must be at least 2");
  end

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] irsh_q;
  logic            bypass_q;
  logic            bist_q;
`ifdef TAP_IDCODE_EN
  logic [31:0]     id_q;
`endif
  logic            tdo_en_q, bsr_shift_q, bsr_capture_q, bsr_update_q;
  logic            bsr_sel_q, bist_run_q;
  dr_e             w_dr_cur, w_dr_nxt;
  logic            w_tdo;

  function automatic dr_e dr_kind(input logic [IR_W-1:0] ir);
    dr_kind = DR_BYP;
    if (ir == c_IR_EXTEST || ir == c_IR_SAMPLE) dr_kind = DR_BSR;
`ifdef TAP_IDCODE_EN
    else if (ir == c_IR_IDCODE) dr_kind = DR_ID;
`endif
    else if (ir == c_IR_RUNBIST) dr_kind = DR_BIST;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:     state_d = tap.tms ? ST_TLR     : ST_RTI;
      ST_RTI:     state_d = tap.tms ? ST_SELDR   : ST_RTI;
      ST_SELDR:   state_d = tap.tms ? ST_SELIR   : ST_CAPDR;
      ST_CAPDR:   state_d = tap.tms ? ST_EX1DR   : ST_SHDR;
      ST_SHDR:    state_d = tap.tms ? ST_EX1DR   : ST_SHDR;
      ST_EX1DR:   state_d = tap.tms ? ST_UPDDR   : ST_PAUSEDR;
      ST_PAUSEDR: state_d = tap.tms ? ST_EX2DR   : ST_PAUSEDR;
      ST_EX2DR:   state_d = tap.tms ? ST_UPDDR   : ST_SHDR;
      ST_UPDDR:   state_d = tap.tms ? ST_SELDR   : ST_RTI;
      ST_SELIR:   state_d = tap.tms ? ST_TLR     : ST_CAPIR;
      ST_CAPIR:   state_d = tap.tms ? ST_EX1IR   : ST_SHIR;
      ST_SHIR:    state_d = tap.tms ? ST_EX1IR   : ST_SHIR;
      ST_EX1IR:   state_d = tap.tms ? ST_UPDIR   : ST_PAUSEIR;
      ST_PAUSEIR: state_d = tap.tms ? ST_EX2IR   : ST_PAUSEIR;
      ST_EX2IR:   state_d = tap.tms ? ST_UPDIR   : ST_SHIR;
      ST_UPDIR:   state_d = tap.tms ? ST_SELDR   : ST_RTI;
      default:    state_d = ST_TLR;
    endcase
  end

  // Active IR moves only on Update-IR or while parked in Test-Logic-Reset.
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_TLR)        ir_d = c_IR_RESET;
    else if (state_q == ST_UPDIR) ir_d = irsh_q;
  end

  assign w_dr_cur = dr_kind(ir_q);
  assign w_dr_nxt = dr_kind(ir_d);

  always_comb begin
    w_tdo = 1'b0;
    if (state_q == ST_SHIR) begin
      w_tdo = irsh_q[0];
    end else if (state_q == ST_SHDR) begin
      case (w_dr_cur)
        DR_BSR:  w_tdo = tap.bsr_scan_out;
        DR_BIST: w_tdo = bist_q;
`ifdef TAP_IDCODE_EN
        DR_ID:   w_tdo = id_q[0];
`endif
        default: w_tdo = bypass_q;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= ST_TLR;
      ir_q          <= c_IR_RESET;
      irsh_q        <= '0;
      bypass_q      <= 1'b0;
      bist_q        <= 1'b0;
`ifdef TAP_IDCODE_EN
      id_q          <= '0;
`endif
      tdo_en_q      <= 1'b0;
      bsr_shift_q   <= 1'b0;
      bsr_capture_q <= 1'b0;
      bsr_update_q  <= 1'b0;
      bsr_sel_q     <= 1'b0;
      bist_run_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;

      if (state_q == ST_CAPIR)     irsh_q <= c_IR_CAPTURE;
      else if (state_q == ST_SHIR) irsh_q <= {tap.tdi, irsh_q[IR_W-1:1]};

      if (state_q == ST_CAPDR) begin
        bypass_q <= 1'b0;
        bist_q   <= tap.bist_done;
`ifdef TAP_IDCODE_EN
        id_q     <= IDCODE_VAL;
`endif
      end else if (state_q == ST_SHDR) begin
        bypass_q <= tap.tdi;
        bist_q   <= tap.tdi;
`ifdef TAP_IDCODE_EN
        id_q     <= {tap.tdi, id_q[31:1]};
`endif
      end

      tdo_en_q      <= (state_d == ST_SHIR) || (state_d == ST_SHDR);
      bsr_shift_q   <= (state_d == ST_SHDR);
      bsr_capture_q <= (state_d == ST_CAPDR) && (w_dr_nxt == DR_BSR);
      bsr_update_q  <= (state_d == ST_UPDDR);
      bsr_sel_q     <= (ir_d == c_IR_EXTEST);
      bist_run_q    <= (state_d == ST_RTI) && (ir_d == c_IR_RUNBIST);
    end
  end

  assign tap.tdo         = w_tdo;
  assign tap.tdo_en      = tdo_en_q;
  assign tap.bsr_scan_in = tap.tdi;
  assign tap.bsr_shift   = bsr_shift_q;
  assign tap.bsr_capture = bsr_capture_q;
  assign tap.bsr_update  = bsr_update_q;
  assign tap.bsr_sel     = bsr_sel_q;
  assign tap.bist_run    = bist_run_q;
  assign tap.tap_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tap_ctrl                                                       |
// | Desc    : Randomized bench for tap_ctrl against a bit-queue TAP model;      |
// |           follows TAP_IDCODE_EN like the design.                            |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_tap_ctrl;

  logic clock;
  logic rst;

  tap_ctrl_if ifc ();

  tap_ctrl #(
    .IR_W       (4),
    .IDCODE_VAL (32'h1000_0001)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .tap   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int {
    M_TLR, M_RTI, M_SELDR, M_CAPDR, M_SHDR, M_EX1DR, M_PAUSEDR, M_EX2DR,
    M_UPDDR, M_SELIR, M_CAPIR, M_SHIR, M_EX1IR, M_PAUSEIR, M_EX2IR, M_UPDIR
  } mstate_e;

  int          n_checks = 0;
  int          n_fail   = 0;
  mstate_e     m_st;
  int          m_ir;
  bit          irq[$];
  bit          drq[$];
  logic [31:0] idv = 32'h1000_0001;
  logic        last_tdo;
  int          cnt_cap, cnt_shift, cnt_upd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Standard 1149.1 state codes as seen on the debug port.
  function automatic logic [3:0] ieee_code(input mstate_e s);
    case (s)
      M_EX2DR:   return 4'h0;  M_EX1DR:   return 4'h1;
      M_SHDR:    return 4'h2;  M_PAUSEDR: return 4'h3;
      M_SELIR:   return 4'h4;  M_UPDDR:   return 4'h5;
      M_CAPDR:   return 4'h6;  M_SELDR:   return 4'h7;
      M_EX2IR:   return 4'h8;  M_EX1IR:   return 4'h9;
      M_SHIR:    return 4'hA;  M_PAUSEIR: return 4'hB;
      M_RTI:     return 4'hC;  M_UPDIR:   return 4'hD;
      M_CAPIR:   return 4'hE;  default:   return 4'hF;
    endcase
  endfunction

  function automatic mstate_e next_st(input mstate_e s, input bit t);
    case (s)
      M_TLR:     return t ? M_TLR   : M_RTI;
      M_RTI:     return t ? M_SELDR : M_RTI;
      M_SELDR:   return t ? M_SELIR : M_CAPDR;
      M_SELIR:   return t ? M_TLR   : M_CAPIR;
      M_CAPDR, M_SHDR:     return t ? M_EX1DR : M_SHDR;
      M_EX1DR:   return t ? M_UPDDR : M_PAUSEDR;
      M_PAUSEDR: return t ? M_EX2DR : M_PAUSEDR;
      M_EX2DR:   return t ? M_UPDDR : M_SHDR;
      M_CAPIR, M_SHIR:     return t ? M_EX1IR : M_SHIR;
      M_EX1IR:   return t ? M_UPDIR : M_PAUSEIR;
      M_PAUSEIR: return t ? M_EX2IR : M_PAUSEIR;
      M_EX2IR:   return t ? M_UPDIR : M_SHIR;
      default:   return t ? M_SELDR : M_RTI;   // both update states
    endcase
  endfunction

  function automatic int reset_ir();
`ifdef TAP_IDCODE_EN
    return 2;
`else
    return 15;
`endif
  endfunction

  // 0 boundary, 1 id, 2 bist, 3 bypass
  function automatic int dr_kind(input int ir);
    if (ir == 0 || ir == 1) return 0;
`ifdef TAP_IDCODE_EN
    if (ir == 2) return 1;
`endif
    if (ir == 3) return 2;
    return 3;
  endfunction

  function automatic logic model_tdo(input logic so);
    if (m_st == M_SHIR) return irq[0];
    if (m_st == M_SHDR) return (dr_kind(m_ir) == 0) ? so : drq[0];
    return 1'b0;
  endfunction

  task automatic model_step(input bit t, input bit d, input bit bd, input bit r);
    if (r) begin
      m_st = M_TLR;
      m_ir = reset_ir();
      irq.delete();
      drq.delete();
    end else begin
      case (m_st)
        M_TLR:   m_ir = reset_ir();
        M_CAPIR: irq = {1'b1, 1'b0, 1'b0, 1'b0};
        M_SHIR:  begin void'(irq.pop_front()); irq.push_back(d); end
        M_UPDIR: begin
          m_ir = 0;
          foreach (irq[i]) m_ir += int'(irq[i]) << i;
        end
        M_CAPDR: begin
          drq.delete();
          case (dr_kind(m_ir))
            1:       for (int i = 0; i < 32; i++) drq.push_back(idv[i]);
            2:       drq.push_back(bd);
            3:       drq.push_back(1'b0);
            default: ;
          endcase
        end
        M_SHDR: if (drq.size() > 0) begin void'(drq.pop_front()); drq.push_back(d); end
        default: ;
      endcase
      m_st = next_st(m_st, t);
    end
  endtask

  task automatic check_outputs();
    check_eq("tap_state",   ifc.tap_state,   ieee_code(m_st));
    check_eq("tdo_en",      ifc.tdo_en,      (m_st == M_SHIR) || (m_st == M_SHDR));
    check_eq("bsr_shift",   ifc.bsr_shift,   m_st == M_SHDR);
    check_eq("bsr_capture", ifc.bsr_capture, (m_st == M_CAPDR) && (dr_kind(m_ir) == 0));
    check_eq("bsr_update",  ifc.bsr_update,  m_st == M_UPDDR);
    check_eq("bsr_sel",     ifc.bsr_sel,     m_ir == 0);
    check_eq("bist_run",    ifc.bist_run,    (m_st == M_RTI) && (m_ir == 3));
  endtask

  task automatic tick(input bit t, input bit d, input bit r);
    bit so, bd;
    so = 1'($urandom);
    bd = 1'($urandom);
    ifc.tms = t; ifc.tdi = d; ifc.bsr_scan_out = so; ifc.bist_done = bd; rst = r;
    #1;
    last_tdo = ifc.tdo;
    check_eq("tdo", ifc.tdo, model_tdo(so));
    check_eq("bsr_scan_in", ifc.bsr_scan_in, d);
    @(posedge clock);
    model_step(t, d, bd, r);
    #1;
    cnt_cap   += int'(ifc.bsr_capture);
    cnt_shift += int'(ifc.bsr_shift);
    cnt_upd   += int'(ifc.bsr_update);
    check_outputs();
  endtask

  task automatic go(input bit t);
    tick(t, 1'($urandom), 1'b0);
  endtask

  task automatic ir_scan(input logic [3:0] v, output logic [3:0] got);
    go(1); go(1); go(0); go(0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, v[i], 1'b0);
      got[i] = last_tdo;
    end
    go(1); go(0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] pat, output logic [31:0] got);
    got = '0;
    go(1); go(0); go(0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, pat[i], 1'b0);
      got[i] = last_tdo;
    end
    go(1); go(0);
  endtask

  initial begin
    logic [3:0]  irw;
    logic [31:0] w, pat, exp_id;

    rst = 1'b1; ifc.tms = 1'b1; ifc.tdi = 1'b0; ifc.bsr_scan_out = 1'b0; ifc.bist_done = 1'b0;
    cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
    repeat (2) @(posedge clock);
    #1;
    m_st = M_TLR; m_ir = reset_ir();
    check_outputs();
    check_eq("reset_tdo", ifc.tdo, 1'b0);

    // Five TMS highs from Run-Test/Idle return to Test-Logic-Reset.
    go(0); go(0);
    repeat (5) go(1);
    check_eq("tlr_state", ifc.tap_state, 4'hF);
    go(0);

    ir_scan(4'b0000, irw);
    check_eq("ir_capture_tdo", irw, 4'b0001);
    check_eq("extest_sel", ifc.bsr_sel, 1'b1);

    ir_scan(4'b1111, irw);
    dr_scan(4, 32'hD, w);
    check_eq("bypass_tdo", w[3:0], 4'b1010);

    ir_scan(4'b0000, irw);
    cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
    dr_scan(8, 32'($urandom), w);
    check_eq("extest_capture_cnt", cnt_cap, 1);
    check_eq("extest_shift_cnt", cnt_shift, 8);
    check_eq("extest_update_cnt", cnt_upd, 1);

    tick(1'b0, 1'b0, 1'b1);
    go(0);
    pat = 32'($urandom);
`ifdef TAP_IDCODE_EN
    exp_id = idv;
`else
    exp_id = {pat[30:0], 1'b0};
`endif
    dr_scan(32, pat, w);
    check_eq("idcode_stream", w, exp_id);

    ir_scan(4'b0011, irw);
    check_eq("bist_run_rti", ifc.bist_run, 1'b1);
    go(1); go(0); go(0); go(0);
    cnt_upd = 0;
    tick(1'b0, 1'b1, 1'b1);
    check_eq("rst_state", ifc.tap_state, 4'hF);
    check_eq("rst_bist_run", ifc.bist_run, 1'b0);
    repeat (4) go(0);
    check_eq("rst_no_update", cnt_upd, 0);

    for (int i = 0; i < 1500; i++)
      tick(1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 15; i++) tick(1'($urandom), 1'($urandom), 1'b0);
      repeat (5) go(1);
      check_eq("five_tms_tlr", ifc.tap_state, 4'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
